// File: rtl/pwm_deadtime_guard.sv
// Shoot-through guard between a 3-phase PWM generator and half-bridge gate pins.
// Optional: define PWM_DEADTIME_GUARD_FAULT_FILTER_EN to require FAULT_FILT_LEN consecutive fault samples.
module pwm_deadtime_guard #(
  parameter int NPH            = 3,
  parameter int DEADTIME       = 25,
  parameter int FAULT_FILT_LEN = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NPH-1:0] pwm_h_in,
  input  logic [NPH-1:0] pwm_l_in,
  input  logic           enable,
  input  logic           fault_n,
  input  logic           fault_clr,
  output logic [NPH-1:0] pwm_h_out,
  output logic [NPH-1:0] pwm_l_out,
  output logic           fault_latched,
  output logic [NPH-1:0] illegal_cmd
);

  localparam int CW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  generate
    if (DEADTIME < 1) begin : g_bad_deadtime
      $error("pwm_deadtime_guard: DEADTIME must be >= 1");
    end
    if (FAULT_FILT_LEN < 1) begin : g_bad_filt_len
      $error("pwm_deadtime_guard: FAULT_FILT_LEN must be >= 1");
    end
  endgenerate

  // Two-flop synchroniser; fault_s_reg is the active-high synchronised fault.
  logic fault_meta_reg;
  logic fault_s_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_meta_reg <= 1'b0;
      fault_s_reg    <= 1'b0;
    end else begin
      fault_meta_reg <= ~fault_n;
      fault_s_reg    <= fault_meta_reg;
    end
  end

  logic fault_set;

`ifdef PWM_DEADTIME_GUARD_FAULT_FILTER_EN
  localparam int FW = $clog2(FAULT_FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FAULT_FILT_LEN);

  logic [FW-1:0] filt_cnt_reg;
  logic [FW-1:0] filt_cnt_next;

  always_comb begin
    filt_cnt_next = '0;
    if (fault_s_reg) begin
      filt_cnt_next = (filt_cnt_reg == FILT_MAX) ? FILT_MAX : filt_cnt_reg + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_next;
    end
  end

  assign fault_set = fault_s_reg && (filt_cnt_next == FILT_MAX);
`else
  assign fault_set = fault_s_reg;
`endif

  logic           clr_ok;
  logic           fault_latched_reg;
  logic           fault_latched_next;
  logic           fault_force;
  logic [NPH-1:0] illegal_reg;
  logic [NPH-1:0] illegal_next;

  // A clear is honoured only while the synchronised fault is inactive; set always wins.
  assign clr_ok             = fault_clr & ~fault_s_reg;
  assign fault_latched_next = fault_set | (fault_latched_reg & ~clr_ok);
  assign illegal_next       = (pwm_h_in & pwm_l_in) | (illegal_reg & ~{NPH{clr_ok}});

  // The registered latch keeps counters parked through the clear cycle; fault_set
  // forces the gates off on the same edge the latch sets.
  assign fault_force = fault_latched_reg | fault_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_latched_reg <= 1'b0;
      illegal_reg       <= '0;
    end else begin
      fault_latched_reg <= fault_latched_next;
      illegal_reg       <= illegal_next;
    end
  end

  assign fault_latched = fault_latched_reg;
  assign illegal_cmd   = illegal_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NPH; gi++) begin : g_phase
      state_t        state_reg;
      state_t        state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          want_hi;
      logic          want_lo;
      logic          h_out_reg;
      logic          l_out_reg;

      assign want_hi = enable & pwm_h_in[gi] & ~pwm_l_in[gi];
      assign want_lo = enable & ~pwm_h_in[gi] & pwm_l_in[gi];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (fault_force) begin
          state_next = ST_DEAD;
          cnt_next   = DT_LOAD;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (want_hi) begin
                state_next = ST_HI;
              end else if (want_lo) begin
                state_next = ST_LO;
              end
            end
            ST_HI: begin
              if (!want_hi) begin
                state_next = ST_DEAD;
                cnt_next   = DT_LOAD;
              end
            end
            ST_LO: begin
              if (!want_lo) begin
                state_next = ST_DEAD;
                cnt_next   = DT_LOAD;
              end
            end
            default: begin
              // Only the request present at expiry matters; the count is never restarted.
              if (cnt_reg == '0) begin
                if (want_hi) begin
                  state_next = ST_HI;
                end else if (want_lo) begin
                  state_next = ST_LO;
                end else begin
                  state_next = ST_IDLE;
                end
              end else begin
                cnt_next = cnt_reg - CW'(1);
              end
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg <= ST_DEAD;
          cnt_reg   <= DT_LOAD;
          h_out_reg <= 1'b0;
          l_out_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          h_out_reg <= (state_next == ST_HI);
          l_out_reg <= (state_next == ST_LO);
        end
      end

      assign pwm_h_out[gi] = h_out_reg;
      assign pwm_l_out[gi] = l_out_reg;
    end
  endgenerate

endmodule
